// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin owner arbiter for a shared I2C bus with four requesters.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   req[3:0]       level request per requester, held high while wanting or owning the bus
//   rel[3:0]       one-cycle release pulse per requester (only the owner's bit matters)
//   gnt[3:0]       one-hot-or-zero grant, registered
//   owner[1:0]     index of the current or most recent grantee, registered
//   busy           high while in GRANT or GAP
//   timeout_pulse  one-cycle strobe when an owner is forced off
//   timeout_id     index of the requester most recently forced off
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to build the grant-hold timeout with
// per-requester lockout. Without it a grant is held until released and the timeout
// outputs are tied to zero.
module i2c_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned GAP_CYCLES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] rel,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout_pulse,
    output logic [1:0] timeout_id
);

    localparam int unsigned NREQ   = 4;
    localparam int unsigned GAP_W  = 8;
    localparam int unsigned HOLD_W = 16;

    // Elaboration-time parameter range checks
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("i2c_bus_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("i2c_bus_arbiter: GAP_CYCLES out of range 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [1:0]         owner_q, owner_d;
    logic               busy_q, busy_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [NREQ-1:0]    eligible;
    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic [1:0]         cand;
    logic               owner_rel;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0]    lockout_q, lockout_d;
    logic               tp_q, tp_d;
    logic [1:0]         tid_q, tid_d;

    assign eligible = req & ~lockout_q;
`else
    assign eligible = req;
`endif

    // Round-robin pick: first eligible index starting at owner+1; the owner itself is tried last
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = owner_q;
        cand       = owner_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand = owner_q + 2'(k);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign owner_rel = rel[owner_q] | ~req[owner_q];

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        gap_cnt_d = gap_cnt_q;
`ifdef I2C_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        tp_d       = 1'b0;
        tid_d      = tid_q;
        // A lockout lasts until its requester drops req
        lockout_d  = lockout_q & req;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    gnt_d   = 4'b0001 << pick_idx;
                    owner_d = pick_idx;
`ifdef I2C_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end

            ST_GRANT: begin
                if (owner_rel) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
`ifdef I2C_ARB_TIMEOUT_EN
                end else if (hold_cnt_q == HOLD_W'(TIMEOUT_CYCLES - 1)) begin
                    // Release takes priority over timeout, so this branch never lands with rel
                    state_d            = ST_GAP;
                    gnt_d              = '0;
                    gap_cnt_d          = '0;
                    tp_d               = 1'b1;
                    tid_d              = owner_q;
                    lockout_d[owner_q] = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
                end
            end

            ST_GAP: begin
                // Last gap cycle arbitrates directly so gnt is low exactly GAP_CYCLES cycles
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (pick_valid) begin
                        state_d = ST_GRANT;
                        gnt_d   = 4'b0001 << pick_idx;
                        owner_d = pick_idx;
`ifdef I2C_ARB_TIMEOUT_EN
                        hold_cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= 2'd3;
            busy_q    <= 1'b0;
            gap_cnt_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            lockout_q  <= '0;
            tp_q       <= 1'b0;
            tid_q      <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            gap_cnt_q <= gap_cnt_d;
`ifdef I2C_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            lockout_q  <= lockout_d;
            tp_q       <= tp_d;
            tid_q      <= tid_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

`ifdef I2C_ARB_TIMEOUT_EN
    assign timeout_pulse = tp_q;
    assign timeout_id    = tid_q;
`else
    assign timeout_pulse = 1'b0;
    assign timeout_id    = 2'd0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed and randomized checks of i2c_bus_arbiter against a
// behavioural model (owner index, gap countdown, hold count, lockout set).
module tb_i2c_bus_arbiter;

    localparam int unsigned TO  = 16;
    localparam int unsigned GAP = 2;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout_pulse;
    logic [1:0] timeout_id;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit       m_on;
    int       m_own;
    int       m_gap;
    int       m_hold;
    bit [3:0] m_lock;
    bit       m_tp;
    int       m_tid;

    i2c_bus_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .rel           (rel),
        .gnt           (gnt),
        .owner         (owner),
        .busy          (busy),
        .timeout_pulse (timeout_pulse),
        .timeout_id    (timeout_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 1'b0; m_own = 3; m_gap = 0; m_hold = 0;
        m_lock = '0; m_tp = 1'b0; m_tid = 0;
    endtask

    // One clock of the arbitration rules, using the inputs sampled at this edge
    task automatic model_update();
        bit [3:0] new_lock;
        bit       found;
        int       idx;
        if (reset) begin
            model_reset();
            return;
        end
        new_lock = m_lock & req;
        m_tp = 1'b0;
        if (m_on) begin
            if (rel[m_own] || !req[m_own]) begin
                m_on = 1'b0; m_gap = GAP;
            end else if (TO_EN && m_hold == TO - 1) begin
                m_on = 1'b0; m_gap = GAP; m_tp = 1'b1; m_tid = m_own;
                new_lock[m_own] = 1'b1;
            end else begin
                m_hold++;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_own + k) % 4;
                if (!found && req[idx] && !m_lock[idx]) begin
                    found = 1'b1; m_own = idx; m_on = 1'b1; m_hold = 0;
                end
            end
        end
        m_lock = new_lock;
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        eg = m_on ? 4'(4'b0001 << m_own) : 4'b0000;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("owner", 32'(owner), 32'(m_own));
        chk("busy", 32'(busy), 32'(m_on || m_gap > 0));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
        chk("timeout_id", 32'(timeout_id), 32'(m_tid));
    endtask

    // Advance one cycle: model follows the edge, outputs checked on the falling edge
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; rel = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        int         order[$];
        int         held;
        int         on_cnt;
        int         tp_cnt;
        logic [3:0] prev_gnt;
        int         den_req;
        int         den_rel;

        reset = 1'b1; req = '0; rel = '0;
        model_reset();
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_owner", 32'(owner), 32'h3);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tp", 32'(timeout_pulse), 32'h0);
        chk("rst_tid", 32'(timeout_id), 32'h0);

        // Basic grant, release and gap length
        do_reset();
        req = 4'b0101;
        chk("no_grant_before_edge", 32'(gnt), 32'h0);
        step();
        chk("first_grant", 32'(gnt), 32'h1);
        step(); step();
        rel = 4'b0001;
        step();
        rel = 4'b0000;
        chk("gap_cycle1", 32'(gnt), 32'h0);
        step();
        chk("gap_cycle2", 32'(gnt), 32'h0);
        step();
        chk("next_grant", 32'(gnt), 32'h4);

        // Non-owner releases ignored, owner drop ends grant
        rel = 4'b1010;
        step();
        rel = 4'b0000;
        chk("nonowner_rel", 32'(gnt), 32'h4);
        req = 4'b0001;
        step();
        chk("drop_gnt", 32'(gnt), 32'h0);
        chk("drop_busy", 32'(busy), 32'h1);
        repeat (4) step();

        // Rotation with all requesters active
        do_reset();
        req = 4'b1111;
        held = 0;
        prev_gnt = '0;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            step();
            rel = '0;
            if (gnt != 4'b0000) begin
                if (gnt != prev_gnt) begin
                    order.push_back(int'(owner));
                    held = 1;
                end else begin
                    held++;
                end
                if (held == 3) rel = gnt;
            end
            if (order.size() > 0 && order.size() < 5) chk("rot_busy", 32'(busy), 32'h1);
            prev_gnt = gnt;
        end
        rel = '0;
        chk("rot_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++)
            chk("rot_order", 32'(order[i]), 32'(i % 4));

        // Long hold by a single requester
        do_reset();
        req = 4'b0010;
        on_cnt = 0; tp_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (gnt == 4'b0010) on_cnt++;
            if (timeout_pulse) tp_cnt++;
        end
        chk("hold_cycles", 32'(on_cnt), TO_EN ? 32'(TO) : 32'd40);
        chk("hold_tp_count", 32'(tp_cnt), TO_EN ? 32'd1 : 32'd0);
        chk("hold_tid", 32'(timeout_id), TO_EN ? 32'd1 : 32'd0);
        req = 4'b0000;
        step();
        req = 4'b0010;
        step();
        chk("regrant_after_toggle", 32'(gnt), TO_EN ? 32'h2 : 32'h0);
        repeat (4) step();

        // Release on grant cycle 15, then on grant cycle 16
        for (int last = 15; last <= 16; last++) begin
            do_reset();
            req = 4'b0010;
            tp_cnt = 0;
            step();
            repeat (last - 1) step();
            rel = 4'b0010;
            step();
            rel = 4'b0000;
            if (timeout_pulse) tp_cnt++;
            chk("late_rel_gnt", 32'(gnt), 32'h0);
            step();
            if (timeout_pulse) tp_cnt++;
            step();
            chk("late_rel_tp", 32'(tp_cnt), 32'd0);
            chk("late_rel_regrant", 32'(gnt), 32'h2);
        end

        // Asynchronous reset while granted
        reset = 1'b1;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'h0);
        chk("async_rst_owner", 32'(owner), 32'h3);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_tp", 32'(timeout_pulse), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        req = '0;

        // Randomized traffic: busy mix first, then sparse releases to provoke timeouts
        for (int c = 0; c < 3000; c++) begin
            den_req = (c < 1500) ? 8 : 64;
            den_rel = (c < 1500) ? 6 : 64;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(den_req - 1) == 0) req[b] = ~req[b];
                rel[b] = ($urandom_range(den_rel - 1) == 0);
            end
            if (c == 2200) begin
                reset = 1'b1;
                #1;
                chk("rand_async_rst_gnt", 32'(gnt), 32'h0);
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
